// File: rtl/uart_pkg.sv
// Shared UART types, default constants and the parity helper (also used by the future transmitter).
// Latency: none, holds types, constants and a pure function only.
// Backpressure: not applicable.
package uart_pkg;

  // Receiver FSM states. PARITY is only reachable when parity is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int CLKS_PER_BIT_9600 = 10417;  // 100 MHz core clock / 9600 baud
  localparam int DEFAULT_DATA_BITS = 8;

  // Parity bit that makes XOR(data bits, parity bit) equal odd_sel.
  // Words narrower than 9 bits must be zero-extended by the caller.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd_sel);
    return (^data) ^ odd_sel;
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// RX front end: 2-flop synchroniser plus 3-sample majority vote around mid-bit.
// Latency: rx_s lags the pin by 2 cycles; sample is combinational at cnt = HALF+1.
// Backpressure: none, free-running; the FSM decides when the strobe matters.
module uart_rx_filter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_rx,
  input  logic [CW-1:0] i_cnt,
  output logic          o_rx_s,
  output logic          o_sample,
  output logic          o_sample_strobe
);

  localparam int HALF = CLKS_PER_BIT / 2;

  logic [1:0] r_sync;
  logic       r_smp_a;
  logic       r_smp_b;
  logic       w_rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_rx};
  end

  assign w_rx_s = r_sync[1];

  // Capture the two earlier points of the majority window (HALF-1 and HALF).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_smp_a <= 1'b1;
      r_smp_b <= 1'b1;
    end else begin
      if (i_cnt == CW'(HALF - 1)) r_smp_a <= w_rx_s;
      if (i_cnt == CW'(HALF))     r_smp_b <= w_rx_s;
    end
  end

  // Third point is the live rx_s, so the vote resolves on the HALF+1 cycle.
  assign o_rx_s          = w_rx_s;
  assign o_sample_strobe = (i_cnt == CW'(HALF + 1));
  assign o_sample        = (r_smp_a & r_smp_b) | (r_smp_a & w_rx_s) | (r_smp_b & w_rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with false-start rejection, stop check, optional parity (UART_RX_PARITY_EN).
// Latency: rx_valid rises the cycle after the stop-bit vote resolves (~frame_bits-0.5 bit times after start).
// Backpressure: one-word holding register with valid/ready; a good word arriving while full is dropped (overrun).
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 r_busy;
  logic                 r_wait_high;

  logic w_rx_s;
  logic w_sample;
  logic w_strobe;
  logic w_wrap;
  logic w_last_bit;
  logic w_par_ok;
  logic w_deliver;

  uart_rx_filter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CW           (CW)
  ) u_filter (
    .clk             (clk),
    .reset           (reset),
    .i_rx            (rx),
    .i_cnt           (r_cnt),
    .o_rx_s          (w_rx_s),
    .o_sample        (w_sample),
    .o_sample_strobe (w_strobe)
  );

  assign w_wrap     = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit_idx == IW'(DATA_BITS - 1));

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  assign w_par_ok = (calc_parity(9'(r_shift), PARITY_ODD) == r_par_bit);
`else
  assign w_par_ok = 1'b1;
`endif

  // A word is good when the stop vote is 1 and parity (if present) matches.
  assign w_deliver = (r_state == STOP) && w_strobe && w_sample && w_par_ok;

  // Bit-timing FSM: start validation, LSB-first shift, optional parity, stop framing check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_wait_high <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      // Free-running bit timer; every state change below also lands on 0.
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          // After a framing error (e.g. a break) the line must go high before a new start counts.
          if (r_wait_high) begin
            if (w_rx_s) r_wait_high <= 1'b0;
          end else if (!w_rx_s) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_strobe && w_sample) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_wrap) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
          end
        end
        DATA: begin
          if (w_strobe) r_shift[r_bit_idx] <= w_sample;
          if (w_wrap) begin
            if (w_last_bit) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_strobe) r_par_bit <= w_sample;
          if (w_wrap)   r_state   <= STOP;
        end
`endif
        STOP: begin
          // Leave at the vote rather than the wrap so a back-to-back start edge is not missed.
          if (w_strobe) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            if (!w_sample) begin
              r_frame_err <= 1'b1;
              r_wait_high <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (!w_par_ok) r_parity_err <= 1'b1;
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: load a good word if empty or being read this cycle, otherwise flag overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = r_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomised frames on the serial pin, checked against a line-level frame model.
// Latency: not applicable (testbench).
// Backpressure: rx_ready driven directly by the stimulus sequence.
module tb_uart_rx_param;

  localparam int C    = 16;
  localparam int DB   = 8;
  localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam bit ODD        = 1'b0;
  localparam int FRAME_BITS = DB + 2 + (PAR_EN ? 1 : 0);
  // Pin-to-rx_valid latency: frame bits before stop, half a bit, resolve, plus synchroniser.
  localparam int LAT = (1 + DB + (PAR_EN ? 1 : 0)) * C + HALF + 2 + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          rx_ready;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  uart_rx_param #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (DB),
    .PARITY_ODD   (ODD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts pulses, records accepted words and checks holding-register stability.
  int            n_fe = 0, n_pe = 0, n_ov = 0, n_vrise = 0, n_stab = 0;
  int            last_rise_cyc = 0;
  logic          busy_at_rise = 1'b1;
  logic [DB-1:0] got[$];
  logic          prev_valid = 1'b0;
  logic          prev_hs = 1'b0;
  logic [DB-1:0] prev_data = '0;

  always @(negedge clk) begin
    #2;
    if (reset === 1'b0) begin
      if (frame_err)  n_fe++;
      if (parity_err) n_pe++;
      if (overrun)    n_ov++;
      if (rx_valid && !prev_valid) begin
        n_vrise++;
        last_rise_cyc = cyc;
        busy_at_rise  = busy;
      end
      if (prev_valid && !prev_hs && (!rx_valid || rx_data !== prev_data)) n_stab++;
      if (rx_valid && rx_ready) got.push_back(rx_data);
    end
    prev_valid = rx_valid && (reset === 1'b0);
    prev_hs    = rx_valid && rx_ready;
    prev_data  = rx_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int rd = 0;

  task automatic expect_word(input string tag, input logic [DB-1:0] exp);
    logic [DB-1:0] w;
    w = 'x;
    if (got.size() > rd) begin
      w = got[rd];
      rd++;
    end
    check(tag, 32'(w), 32'(exp));
  endtask

  // Parity bit a well-behaved transmitter would send.
  function automatic logic good_par(input logic [DB-1:0] d);
    return (^d) ^ ODD;
  endfunction

  // Frame outcome from the line-level rules: bit1 = parity error, bit0 = framing error.
  function automatic logic [1:0] frame_outcome(input logic [DB-1:0] d, input logic par, input logic stp);
    logic pe;
    pe = PAR_EN && (((^d) ^ par) != ODD);
    return {pe, !stp};
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stp);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stp);
    rx = 1'b1;
  endtask

  initial begin
    int            fe0, pe0, ov0, vr0, t_drop, lat, exp_fe, exp_pe;
    logic [DB-1:0] d;
    logic          par, stp;
    logic [1:0]    oc;
    logic [DB-1:0] expq[$];

    reset = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Clean 0xA5 with a ready consumer.
    fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
    t_drop = cyc;
    send_frame(8'hA5, good_par(8'hA5), 1'b1);
    repeat (4) @(negedge clk);
    check("a5_count", got.size() - rd, 1);
    expect_word("a5_data", 8'hA5);
    check("a5_no_err", (n_fe - fe0) + (n_pe - pe0) + (n_ov - ov0), 0);
    lat = last_rise_cyc - t_drop;
    check("a5_latency_window", (lat >= LAT && lat <= LAT + 2), 1);
    check("a5_busy_low_at_valid", busy_at_rise, 0);
    check("a5_valid_consumed", rx_valid, 0);

    // Four-cycle glitch: false start must be rejected silently.
    fe0 = n_fe; vr0 = n_vrise;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_seen", busy, 1);
    repeat (3 * C) @(negedge clk);
    check("glitch_busy_back", busy, 0);
    check("glitch_no_valid", n_vrise - vr0, 0);
    check("glitch_no_frame_err", n_fe - fe0, 0);

    // Bad stop bit, then a good frame.
    fe0 = n_fe; vr0 = n_vrise;
    send_frame(8'h3C, good_par(8'h3C), 1'b0);
    repeat (C) @(negedge clk);
    check("fe_pulse_once", n_fe - fe0, 1);
    check("fe_no_valid", n_vrise - vr0, 0);
    send_frame(8'h11, good_par(8'h11), 1'b1);
    repeat (4) @(negedge clk);
    expect_word("after_fe_data", 8'h11);
    check("after_fe_no_new_fe", n_fe - fe0, 1);

    // Back-to-back with consumer stalled: second word dropped with overrun.
    ov0 = n_ov;
    rx_ready = 1'b0;
    send_frame(8'h01, good_par(8'h01), 1'b1);
    send_frame(8'h02, good_par(8'h02), 1'b1);
    repeat (4) @(negedge clk);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h01);
    check("ovr_pulse", n_ov - ov0, 1);
    @(negedge clk) rx_ready = 1'b1;
    @(negedge clk) rx_ready = 1'b0;
    check("ovr_valid_cleared", rx_valid, 0);
    expect_word("ovr_read_word", 8'h01);
    check("ovr_nothing_more", got.size() - rd, 0);
    rx_ready = 1'b1;

    // Reset in the middle of data bit 4, then a clean 0x7E.
    vr0 = n_vrise;
    d = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (HALF) @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_valid", rx_valid, 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2 * C) @(negedge clk);
    check("mid_no_partial", n_vrise - vr0, 0);
    send_frame(8'h7E, good_par(8'h7E), 1'b1);
    repeat (4) @(negedge clk);
    expect_word("after_rst_data", 8'h7E);

    // Break: long low produces exactly one framing error.
    fe0 = n_fe; vr0 = n_vrise;
    rx = 1'b0;
    repeat (3 * FRAME_BITS * C) @(negedge clk);
    rx = 1'b1;
    repeat (2 * C) @(negedge clk);
    check("break_one_fe", n_fe - fe0, 1);
    check("break_no_valid", n_vrise - vr0, 0);
    send_frame(8'h55, good_par(8'h55), 1'b1);
    repeat (4) @(negedge clk);
    expect_word("after_break_data", 8'h55);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x03 has two ones, so parity 1 is wrong and parity 0 is right.
    pe0 = n_pe; vr0 = n_vrise;
    send_frame(8'h03, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("par_bad_pulse", n_pe - pe0, 1);
    check("par_bad_no_valid", n_vrise - vr0, 0);
    send_frame(8'h03, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    expect_word("par_good_data", 8'h03);
    check("par_good_no_pe", n_pe - pe0, 1);
`endif

    // Randomised frames against the frame-outcome model.
    fe0 = n_fe; pe0 = n_pe; ov0 = n_ov;
    exp_fe = 0; exp_pe = 0;
    for (int k = 0; k < 24; k++) begin
      d   = DB'($urandom);
      stp = ($urandom_range(0, 4) != 0);
      par = good_par(d) ^ (PAR_EN && ($urandom_range(0, 3) == 0));
      oc  = frame_outcome(d, par, stp);
      if (oc == 2'b00) expq.push_back(d);
      exp_fe += int'(oc[0]);
      exp_pe += int'(oc[1]);
      send_frame(d, par, stp);
      if (!stp) repeat (C + $urandom_range(0, C)) @(negedge clk);
      else      repeat ($urandom_range(0, 2 * C)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("rand_count", got.size() - rd, expq.size());
    foreach (expq[j]) expect_word("rand_word", expq[j]);
    check("rand_frame_errs", n_fe - fe0, exp_fe);
    check("rand_parity_errs", n_pe - pe0, exp_pe);
    check("rand_no_overrun", n_ov - ov0, 0);
    check("data_stable_while_valid", n_stab, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver; next generation of the team's fixed 9600-baud, 8-bit serial receiver.
- Configurable bit period and data width.
- Features: false-start rejection, 3-sample majority vote, stop-bit framing check, valid/ready output handshake with overrun detection, optional parity.
- Sits between the board RX pin (e.g. Bluetooth module) and consumer logic.

Parameters:
- CLKS_PER_BIT, 10417: clk cycles per serial bit (100 MHz / 9600). Must be >= 8.
- DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- PARITY_ODD, 0: 1 = odd parity, 0 = even. Used only when UART_RX_PARITY_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_BITS  received word. Stable while rx_valid = 1.
- rx_valid  out  1  rx_data holds an unread word.
- rx_ready  in  1  consumer accepts the word on a cycle where rx_valid && rx_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- parity_err  out  1  one-cycle pulse: parity mismatch. Tied 0 without the macro.
- overrun  out  1  one-cycle pulse: a good word was dropped because the holding register was full.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - Synchroniser flops = 1; FSM = IDLE; counters = 0.
  - rx_data = 0; rx_valid = 0; all error pulses = 0; busy = 0.
- Synchroniser: rx passes through 2 flops to give rx_s. All logic uses rx_s only.
- Bit timer:
  - cnt is $clog2(CLKS_PER_BIT) wide, HALF = CLKS_PER_BIT/2.
  - cnt clears on every state entry and wraps to 0 at CLKS_PER_BIT-1.
  - The sample value is the majority of rx_s at cnt = HALF-1, HALF and HALF+1. It is resolved at cnt = HALF+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s == 0 -> START.
  - START: on a resolved sample of 1 -> IDLE (glitch, no outputs). On 0, wait for the wrap, then -> DATA.
  - DATA: shift the sample in at bit index bit_idx (0..DATA_BITS-1). At the wrap after index DATA_BITS-1 -> PARITY if the macro is defined, else -> STOP.
  - PARITY: store the sample; at the wrap -> STOP.
  - STOP: at sample resolution, go directly -> IDLE without waiting for the wrap, so back-to-back frames are caught.
- STOP outcome, evaluated on the resolution cycle:
  - Sample 0: pulse frame_err; discard the word.
  - Parity mismatch: pulse parity_err; discard the word. If both fail, pulse both.
  - Otherwise the word is good and is delivered.
- Delivery of a good word, on the cycle after the STOP resolution:
  - rx_valid = 0, or rx_ready = 1 on that cycle: load rx_data and set rx_valid = 1. Loading and consuming on the same cycle gives no overrun.
  - rx_valid = 1 and rx_ready = 0: keep the old rx_data, drop the new word, pulse overrun.
- Handshake: rx_valid clears on the cycle after rx_valid && rx_ready, unless a new word loads on that same cycle.
- Latency from the first low at rx_s:
  - (1 + DATA_BITS [+1 with parity]) * CLKS_PER_BIT + HALF + 2 cycles to rx_valid.
  - Add 2 cycles from the pin, for the synchroniser.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. A partial word is never delivered.
- rx held low (break): one frame_err per break. The FSM waits in IDLE for rx_s to return to 1 before accepting a new start.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
  - Defined: the PARITY state exists. The XOR of the data bits and the parity bit must equal PARITY_ODD, otherwise parity_err pulses. Frame length is DATA_BITS+3 bits.
  - Undefined: no PARITY state and no parity logic; parity_err is constant 0. Frame length is DATA_BITS+2 bits.

Decomposition:
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the default constants CLKS_PER_BIT_9600 = 10417 and DEFAULT_DATA_BITS = 8;
  - a parity-calculation function, shared with the future transmitter.
- Sub-module uart_rx_filter: 2-flop synchroniser plus 3-sample majority voter. Its outputs are rx_s, sample and sample_strobe.
- The FSM, shifter and holding register stay in the top module.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8 unless noted):
- Send 0xA5 with a good stop bit, rx_ready=1 -> one rx_valid cycle with rx_data=0xA5; no error pulses; busy drops at the STOP resolution.
- Drive a 4-cycle low glitch on an idle line -> FSM returns to IDLE from START; no rx_valid, no frame_err.
- Send 0x3C with the stop bit forced to 0 -> frame_err pulses once; rx_valid stays 0; the next good 0x11 is received correctly.
- Send 0x01 then 0x02 back-to-back with rx_ready=0 -> rx_data=0x01 held; overrun pulses at the second delivery; asserting rx_ready then clears rx_valid.
- Assert reset in the middle of data bit 4 -> all outputs return to reset values immediately; a following clean 0x7E frame is received.
- With UART_RX_PARITY_EN defined and PARITY_ODD=0, send 0x03 with parity bit 1 -> parity_err pulses and there is no rx_valid. Resend with parity bit 0 -> rx_data=0x03.
